// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//
// Operand-forwarding and hazard-control unit for a 5-stage pipeline. It sits
// beside the ID/EX register and does four things:
//   * selects the EX operand sources (register file, EX/MEM or MEM/WB bypass)
//   * inserts LOAD_LAT bubbles when a load feeds the instruction in ID
//   * freezes the whole pipeline while a data-memory access is not ready
//   * optionally counts the hazard cycles it causes
//
// Optional feature macro: HAZ_PERF_CNT_EN
//   defined   -> haz_cnt is a saturating count of edges with stall_id = 1
//   undefined -> no counter register exists and haz_cnt is tied to 0
//
// Parameters:
//   REG_AW   register-specifier width (register 0 is hardwired zero)
//   LOAD_LAT load-use bubbles per hazard, legal range 1..7
//   CNT_W    hazard-cycle counter width
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   id_rs, id_rt               sources of the instruction in ID
//   ex_rs, ex_rt, ex_rd        sources / destination of the instruction in EX
//   ex_regwrite, ex_memread    control bits of the instruction in EX
//   mem_rd, mem_regwrite       destination / control of the instruction in MEM
//   mem_access, mem_ready      MEM-stage load/store and its completion
//   wb_rd, wb_regwrite         destination / control of the instruction in WB
//   ctrl_flush                 control-flow flush from the branch unit
//   fwd_a, fwd_b               operand select: 00 RF, 10 EX/MEM, 01 MEM/WB
//   stall_if, stall_id         hold the PC and the IF/ID register
//   flush_ex                   load a bubble into ID/EX
//   freeze                     hold every pipeline register
//   haz_cnt                    hazard-cycle count
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic              mem_access,
    input  logic              mem_ready,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    input  logic              ctrl_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_ex,
    output logic              freeze,
    output logic [CNT_W-1:0]  haz_cnt
);

    typedef enum logic {
        IDLE     = 1'b0,
        LU_STALL = 1'b1
    } state_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b01;

    // Bubbles still owed after the first one, loaded on entry to LU_STALL.
    localparam logic [2:0] BCNT_INIT = 3'(LOAD_LAT - 1);

    state_t     state_q, state_d;
    logic [2:0] bcnt_q, bcnt_d;

    logic       lu;
    logic       mem_wait;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    // -----------------------------------------------------------------------
    // Forwarding: the youngest producer (EX/MEM) wins over MEM/WB. Register 0
    // is never forwarded because it always reads as zero.
    // -----------------------------------------------------------------------
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == src))
            return SEL_MEM;
        else if (wb_regwrite && (wb_rd != '0) && (wb_rd == src))
            return SEL_WB;
        else
            return SEL_RF;
    endfunction

    assign fwd_a_raw = fwd_sel(ex_rs);
    assign fwd_b_raw = fwd_sel(ex_rt);

    // Load in EX whose destination is read by the instruction in ID.
    assign lu = ex_memread & ex_regwrite & (ex_rd != '0) &
                ((ex_rd == id_rs) | (ex_rd == id_rt));

    assign mem_wait = mem_access & ~mem_ready;

    // -----------------------------------------------------------------------
    // Next-state and output logic.
    // Priority: reset, memory freeze, control flush, load-use.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        fwd_a    = SEL_RF;
        fwd_b    = SEL_RF;
        stall_if = 1'b0;
        stall_id = 1'b0;
        flush_ex = 1'b0;
        freeze   = 1'b0;

        // Outputs must read 0 the moment rst_n falls, not at the next edge,
        // so even the purely combinational paths are gated by it.
        if (!rst_n) begin
            state_d = IDLE;
            bcnt_d  = '0;
        end else begin
            // Forwarding stays live through freeze and bubble cycles.
            fwd_a = fwd_a_raw;
            fwd_b = fwd_b_raw;

            if (mem_wait) begin
                // Hold everything; state and bcnt keep their values and a
                // pending load-use waits until the memory completes.
                freeze   = 1'b1;
                stall_if = 1'b1;
                stall_id = 1'b1;
            end else if (ctrl_flush) begin
                // The wrong-path instructions are discarded by the flush, so
                // any outstanding bubbles are abandoned.
                state_d = IDLE;
                bcnt_d  = '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (lu) begin
                            stall_if = 1'b1;
                            stall_id = 1'b1;
                            flush_ex = 1'b1;
                            if (LOAD_LAT > 1) begin
                                state_d = LU_STALL;
                                bcnt_d  = BCNT_INIT;
                            end
                        end
                    end
                    LU_STALL: begin
                        // EX holds bubbles here, so lu is not re-evaluated.
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_ex = 1'b1;
                        bcnt_d   = bcnt_q - 3'd1;
                        if (bcnt_q == 3'd1)
                            state_d = IDLE;
                    end
                    default: begin
                        state_d = IDLE;
                        bcnt_d  = '0;
                    end
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Hazard-cycle counter: one count per edge with stall_id high (bubble or
    // freeze), saturating at all-ones.
    // -----------------------------------------------------------------------
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] haz_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            haz_cnt_q <= '0;
        else if (stall_id && (haz_cnt_q != {CNT_W{1'b1}}))
            haz_cnt_q <= haz_cnt_q + 1'b1;
    end

    assign haz_cnt = haz_cnt_q;
`else
    assign haz_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_unit
//
// Two instances share one set of inputs: u_lat1 (LOAD_LAT = 1) and u_lat3
// (LOAD_LAT = 3). A behavioural model tracks, per instance, how many bubbles
// are still owed and the hazard-cycle count; a compare process checks every
// output of both instances on each falling edge. Directed sequences add
// hand-computed literal expectations for the scenarios of interest.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fwd_hazard_unit;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAZ_PERF_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif
    localparam int LAT [2] = '{1, 3};

    logic              clk = 1'b0;
    logic              rst_n;
    logic [REG_AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic              ex_regwrite, ex_memread, mem_regwrite, mem_access;
    logic              mem_ready, wb_regwrite, ctrl_flush;

    logic [1:0]        fa [2];
    logic [1:0]        fb [2];
    logic              sif [2];
    logic              sid [2];
    logic              fex [2];
    logic              frz [2];
    logic [CNT_W-1:0]  hc [2];

    int total = 0;
    int bad   = 0;

    // Model state: bubbles still owed after the current one, and hazard count.
    int rem [2];
    int cnt [2];

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_AW(REG_AW), .LOAD_LAT(1), .CNT_W(CNT_W)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .mem_access(mem_access), .mem_ready(mem_ready),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .ctrl_flush(ctrl_flush),
        .fwd_a(fa[0]), .fwd_b(fb[0]), .stall_if(sif[0]), .stall_id(sid[0]),
        .flush_ex(fex[0]), .freeze(frz[0]), .haz_cnt(hc[0])
    );

    fwd_hazard_unit #(.REG_AW(REG_AW), .LOAD_LAT(3), .CNT_W(CNT_W)) u_lat3 (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .mem_access(mem_access), .mem_ready(mem_ready),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .ctrl_flush(ctrl_flush),
        .fwd_a(fa[1]), .fwd_b(fb[1]), .stall_if(sif[1]), .stall_id(sid[1]),
        .flush_ex(fex[1]), .freeze(frz[1]), .haz_cnt(hc[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [1:0] ref_fwd(input logic [REG_AW-1:0] src);
        if (mem_regwrite && mem_rd != 0 && mem_rd == src) return 2'b10;
        if (wb_regwrite && wb_rd != 0 && wb_rd == src)    return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit ref_lu();
        return ex_memread && ex_regwrite && ex_rd != 0 && (ex_rd == id_rs || ex_rd == id_rt);
    endfunction

    // Expected control outputs this cycle and the owed-bubble count after the edge.
    function automatic void ref_ctrl(input int i, output bit st, output bit fl,
                                     output bit fz, output int nrem);
        fz = mem_access && !mem_ready;
        if (fz) begin
            st = 1; fl = 0; nrem = rem[i];
        end else if (ctrl_flush) begin
            st = 0; fl = 0; nrem = 0;
        end else if (rem[i] > 0) begin
            st = 1; fl = 1; nrem = rem[i] - 1;
        end else if (ref_lu()) begin
            st = 1; fl = 1; nrem = LAT[i] - 1;
        end else begin
            st = 0; fl = 0; nrem = 0;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                rem[i] <= 0;
                cnt[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit st, fl, fz;
                int nrem;
                ref_ctrl(i, st, fl, fz, nrem);
                rem[i] <= nrem;
                if (st && cnt[i] < CNT_MAX) cnt[i] <= cnt[i] + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit st, fl, fz;
            int nrem;
            string p;
            p = (i == 0) ? "lat1" : "lat3";
            if (!rst_n) begin
                st = 0; fl = 0; fz = 0;
                check({p, ".fwd_a"}, 32'(fa[i]), 32'd0);
                check({p, ".fwd_b"}, 32'(fb[i]), 32'd0);
            end else begin
                ref_ctrl(i, st, fl, fz, nrem);
                check({p, ".fwd_a"}, 32'(fa[i]), 32'(ref_fwd(ex_rs)));
                check({p, ".fwd_b"}, 32'(fb[i]), 32'(ref_fwd(ex_rt)));
            end
            check({p, ".stall_if"}, 32'(sif[i]), 32'(st));
            check({p, ".stall_id"}, 32'(sid[i]), 32'(st));
            check({p, ".flush_ex"}, 32'(fex[i]), 32'(fl));
            check({p, ".freeze"},   32'(frz[i]), 32'(fz));
            check({p, ".haz_cnt"},  32'(hc[i]), (CNT_ON && rst_n) ? 32'(cnt[i]) : 32'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0;
        mem_rd = 0; wb_rd = 0;
        ex_regwrite = 0; ex_memread = 0; mem_regwrite = 0; wb_regwrite = 0;
        mem_access = 0; mem_ready = 0; ctrl_flush = 0;
    endtask

    task automatic reset_dut();
        tick();
        clear_inputs();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic load_use();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 3; id_rt = 3;
    endtask

    task automatic drop_load();
        ex_memread = 0; ex_regwrite = 0; ex_rd = 0; id_rt = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst_n = 0;
        #1;
        check("async_reset_initial.stall_id", 32'(sid[1]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;

        // ---- 1: forwarding priority and register 0 ----
        mem_rd = 5; wb_rd = 5; mem_regwrite = 1; wb_regwrite = 1; ex_rs = 5; ex_rt = 5;
        @(negedge clk);
        check("t1.fwd_a_mem", 32'(fa[0]), 32'b10);
        check("t1.fwd_b_mem", 32'(fb[0]), 32'b10);
        tick(); mem_regwrite = 0;
        @(negedge clk);
        check("t1.fwd_a_wb", 32'(fa[0]), 32'b01);
        check("t1.fwd_b_wb", 32'(fb[0]), 32'b01);
        tick(); mem_regwrite = 1; mem_rd = 0; wb_rd = 0; ex_rs = 0; ex_rt = 0;
        @(negedge clk);
        check("t1.fwd_a_r0", 32'(fa[0]), 32'b00);
        check("t1.fwd_b_r0", 32'(fb[0]), 32'b00);
        tick(); mem_rd = 7; wb_rd = 5; wb_regwrite = 1; ex_rs = 5; ex_rt = 7;
        @(negedge clk);
        check("t1.fwd_a_mix", 32'(fa[1]), 32'b01);
        check("t1.fwd_b_mix", 32'(fb[1]), 32'b10);

        // ---- 2/3: load-use, LOAD_LAT 1 and 3 ----
        reset_dut();
        load_use();
        @(negedge clk);
        check("t2.lat1_bubble", 32'({sif[0], sid[0], fex[0]}), 32'b111);
        check("t3.lat3_bubble1", 32'({sif[1], sid[1], fex[1]}), 32'b111);
        tick(); drop_load();
        @(negedge clk);
        check("t2.lat1_done", 32'({sif[0], sid[0], fex[0]}), 32'b000);
        check("t3.lat3_bubble2", 32'(fex[1]), 32'd1);
        tick();
        @(negedge clk);
        check("t3.lat3_bubble3", 32'(fex[1]), 32'd1);
        tick();
        @(negedge clk);
        check("t3.lat3_done", 32'(sid[1]), 32'd0);
        check("t2.lat1_cnt", 32'(hc[0]), CNT_ON ? 32'd1 : 32'd0);
        check("t3.lat3_cnt", 32'(hc[1]), CNT_ON ? 32'd3 : 32'd0);

        // ---- 4: freeze during bubbles ----
        reset_dut();
        load_use();
        @(negedge clk);
        tick(); drop_load(); mem_access = 1; mem_ready = 0;
        @(negedge clk);
        check("t4.freeze1", 32'({frz[1], sid[1], fex[1]}), 32'b110);
        tick();
        @(negedge clk);
        check("t4.freeze2", 32'({frz[1], sif[1], fex[1]}), 32'b110);
        tick(); mem_access = 0;
        @(negedge clk);
        check("t4.resume1", 32'({frz[1], fex[1]}), 32'b01);
        tick();
        @(negedge clk);
        check("t4.resume2", 32'(fex[1]), 32'd1);
        tick();
        @(negedge clk);
        check("t4.done", 32'(sid[1]), 32'd0);
        check("t4.lat3_cnt", 32'(hc[1]), CNT_ON ? 32'd5 : 32'd0);
        check("t4.lat1_cnt", 32'(hc[0]), CNT_ON ? 32'd3 : 32'd0);

        // pending load-use held off by freeze in IDLE
        tick(); load_use(); mem_access = 1; mem_ready = 0;
        @(negedge clk);
        check("t4.lu_held", 32'({frz[0], fex[0]}), 32'b10);
        tick(); mem_ready = 1;
        @(negedge clk);
        check("t4.lu_after", 32'({frz[0], fex[0]}), 32'b01);
        tick(); clear_inputs();
        repeat (3) tick();

        // ---- 5: ctrl_flush during LU_STALL, and freeze outranking it ----
        reset_dut();
        load_use();
        @(negedge clk);
        tick(); drop_load(); ctrl_flush = 1;
        @(negedge clk);
        check("t5.flush_same", 32'({sif[1], sid[1], fex[1]}), 32'b000);
        tick(); ctrl_flush = 0;
        @(negedge clk);
        check("t5.no_bubble1", 32'(sid[1]), 32'd0);
        tick();
        @(negedge clk);
        check("t5.no_bubble2", 32'(fex[1]), 32'd0);
        tick(); load_use();
        @(negedge clk);
        tick(); drop_load(); ctrl_flush = 1; mem_access = 1; mem_ready = 0;
        @(negedge clk);
        check("t5.freeze_wins", 32'({frz[1], sid[1], fex[1]}), 32'b110);
        tick(); ctrl_flush = 0; mem_access = 0;
        @(negedge clk);
        check("t5.bubble_kept", 32'(fex[1]), 32'd1);
        repeat (3) tick();

        // ---- 6: asynchronous reset mid-LU_STALL ----
        reset_dut();
        load_use();
        @(negedge clk);
        tick(); drop_load(); mem_rd = 5; mem_regwrite = 1; ex_rs = 5;
        @(negedge clk);
        check("t6.pre_stall", 32'(sid[1]), 32'd1);
        check("t6.pre_fwd", 32'(fa[1]), 32'b10);
        #2 rst_n = 0;
        #1;
        check("t6.async_ctrl", 32'({sif[1], sid[1], fex[1], frz[1]}), 32'b0000);
        check("t6.async_fwd", 32'({fa[1], fb[1]}), 32'b0000);
        check("t6.async_cnt", 32'(hc[1]), 32'd0);
        tick(); rst_n = 1; clear_inputs();
        @(negedge clk);
        check("t6.no_bubble1", 32'(sid[1]), 32'd0);
        tick();
        @(negedge clk);
        check("t6.no_bubble2", 32'(fex[1]), 32'd0);
        check("t6.cnt_zero", 32'(hc[1]), 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
